// File: rtl/button_debounce.sv
// Push-button debouncer: 2-flop synchronizer, free-running sample prescaler and a
// four-state stability FSM producing a registered level plus rise/fall pulses.
// Optional auto-repeat while held is enabled by defining DEBOUNCE_REPEAT_EN;
// without it rep is tied low and no repeat counter exists.
module button_debounce #(
   parameter int unsigned SAMPLE_DIV   = 1000,
   parameter int unsigned STABLE_TICKS = 8,
   parameter int unsigned REPEAT_DELAY = 500,
   parameter int unsigned REPEAT_RATE  = 100
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_in,
   output logic level,
   output logic rise,
   output logic fall,
   output logic rep
);

   typedef enum logic [1:0] {
      StLow      = 2'd0,
      StWaitHigh = 2'd1,
      StHigh     = 2'd2,
      StWaitLow  = 2'd3
   } state_e;

   localparam logic [15:0] DIV_LAST = 16'(SAMPLE_DIV - 1);
   localparam logic [7:0]  STABLE_N = 8'(STABLE_TICKS);

   // Elaboration-time range checks on the configuration.
   if (SAMPLE_DIV < 2 || SAMPLE_DIV > 65535) begin : g_bad_sample_div
      $error("SAMPLE_DIV must lie in 2..65535");
   end
   if (STABLE_TICKS < 1 || STABLE_TICKS > 255) begin : g_bad_stable_ticks
      $error("STABLE_TICKS must lie in 1..255");
   end
   if (REPEAT_DELAY < 1 || REPEAT_DELAY > 65535) begin : g_bad_repeat_delay
      $error("REPEAT_DELAY must lie in 1..65535");
   end
   if (REPEAT_RATE < 1 || REPEAT_RATE > 65535) begin : g_bad_repeat_rate
      $error("REPEAT_RATE must lie in 1..65535");
   end

   state_e      state;
   logic        sync1;
   logic        btn_s;
   logic [15:0] presc;
   logic        tick;
   logic [7:0]  stable_cnt;
   logic [7:0]  cnt_inc;

   assign tick    = (presc == DIV_LAST);
   // Saturating increment so the stable counter can never wrap.
   assign cnt_inc = (stable_cnt == 8'hFF) ? stable_cnt : stable_cnt + 8'd1;

   // Two-flop synchronizer; btn_s is the only consumer-visible copy of btn_in.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1 <= 1'b0;
         btn_s <= 1'b0;
      end else begin
         sync1 <= btn_in;
         btn_s <= sync1;
      end
   end

   // Free-running prescaler, independent of FSM state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         presc <= 16'd0;
      end else if (tick) begin
         presc <= 16'd0;
      end else begin
         presc <= presc + 16'd1;
      end
   end

   // Stability FSM with registered level and single-cycle edge pulses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= StLow;
         stable_cnt <= 8'd0;
         level      <= 1'b0;
         rise       <= 1'b0;
         fall       <= 1'b0;
      end else begin
         rise <= 1'b0;
         fall <= 1'b0;
         if (tick) begin
            case (state)
               StLow: begin
                  if (btn_s) begin
                     if (STABLE_N <= 8'd1) begin
                        state      <= StHigh;
                        stable_cnt <= 8'd0;
                        level      <= 1'b1;
                        rise       <= 1'b1;
                     end else begin
                        state      <= StWaitHigh;
                        stable_cnt <= 8'd1;
                     end
                  end
               end
               StWaitHigh: begin
                  if (!btn_s) begin
                     state      <= StLow;
                     stable_cnt <= 8'd0;
                  end else if (cnt_inc >= STABLE_N) begin
                     state      <= StHigh;
                     stable_cnt <= 8'd0;
                     level      <= 1'b1;
                     rise       <= 1'b1;
                  end else begin
                     stable_cnt <= cnt_inc;
                  end
               end
               StHigh: begin
                  if (!btn_s) begin
                     if (STABLE_N <= 8'd1) begin
                        state      <= StLow;
                        stable_cnt <= 8'd0;
                        level      <= 1'b0;
                        fall       <= 1'b1;
                     end else begin
                        state      <= StWaitLow;
                        stable_cnt <= 8'd1;
                     end
                  end
               end
               StWaitLow: begin
                  if (btn_s) begin
                     state      <= StHigh;
                     stable_cnt <= 8'd0;
                  end else if (cnt_inc >= STABLE_N) begin
                     state      <= StLow;
                     stable_cnt <= 8'd0;
                     level      <= 1'b0;
                     fall       <= 1'b1;
                  end else begin
                     stable_cnt <= cnt_inc;
                  end
               end
               default: begin
                  state      <= StLow;
                  stable_cnt <= 8'd0;
               end
            endcase
         end
      end
   end

`ifdef DEBOUNCE_REPEAT_EN
   localparam logic [15:0] DELAY_N = 16'(REPEAT_DELAY);
   localparam logic [15:0] RATE_N  = 16'(REPEAT_RATE);

   logic [15:0] rep_cnt;
   logic [15:0] rep_next;
   logic        rep_armed;
   logic        rep_q;

   assign rep_next = rep_cnt + 16'd1;
   assign rep      = rep_q;

   // Repeat timer: counts held ticks in HIGH, first pulse after DELAY, then every RATE.
   // The tick that sees the button released is not counted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rep_cnt   <= 16'd0;
         rep_armed <= 1'b0;
         rep_q     <= 1'b0;
      end else begin
         rep_q <= 1'b0;
         if (state != StHigh) begin
            rep_cnt   <= 16'd0;
            rep_armed <= 1'b0;
         end else if (tick && btn_s) begin
            if (!rep_armed && rep_next >= DELAY_N) begin
               rep_q     <= 1'b1;
               rep_cnt   <= 16'd0;
               rep_armed <= 1'b1;
            end else if (rep_armed && rep_next >= RATE_N) begin
               rep_q   <= 1'b1;
               rep_cnt <= 16'd0;
            end else begin
               rep_cnt <= rep_next;
            end
         end
      end
   end
`else
   assign rep = 1'b0;
`endif

endmodule

// File: tb/tb_button_debounce.sv
// Directed bench for button_debounce with SAMPLE_DIV=4, STABLE_TICKS=3,
// REPEAT_DELAY=5, REPEAT_RATE=2. Repeat expectations follow DEBOUNCE_REPEAT_EN.
module tb_button_debounce;

   logic clk;
   logic rst;
   logic btn_in;
   logic level;
   logic rise;
   logic fall;
   logic rep;

   int n_pass  = 0;
   int n_total = 0;

   // Pulse/edge monitor, sampled on the falling edge away from DUT updates.
   int   rise_n    = 0;
   int   fall_n    = 0;
   int   rep_n     = 0;
   int   overlap_n = 0;
   logic lvl_d     = 1'b0;
   logic tgl       = 1'b0;
   logic tgl_clr   = 1'b0;

   typedef struct {
      logic btn;
      int   cycles;
      logic exp_level;
      int   exp_rise;
      int   exp_fall;
      int   exp_rep;
   } vec_t;

   vec_t vecs[9];

   button_debounce #(
      .SAMPLE_DIV  (4),
      .STABLE_TICKS(3),
      .REPEAT_DELAY(5),
      .REPEAT_RATE (2)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .btn_in(btn_in),
      .level (level),
      .rise  (rise),
      .fall  (fall),
      .rep   (rep)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (rise) rise_n <= rise_n + 1;
      if (fall) fall_n <= fall_n + 1;
      if (rep) rep_n <= rep_n + 1;
      if (rise && fall) overlap_n <= overlap_n + 1;
      lvl_d <= level;
      if (tgl_clr) tgl <= 1'b0;
      else if (lvl_d && !level) tgl <= ~tgl;
   end

   task automatic check(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, required %0d", name, act, exp);
   endtask

   task automatic check_range(input string name, input int act, input int lo, input int hi);
      n_total++;
      if (act >= lo && act <= hi) n_pass++;
      else $display("FAIL %s: got %0d, required %0d..%0d", name, act, lo, hi);
   endtask

   // Count rising edges (including the one that samples the new btn_in) until level==target.
   task automatic wait_level(input logic target, output int n);
      n = 0;
      while (level !== target && n < 40) begin
         @(posedge clk);
         #1;
         n++;
      end
   endtask

   initial begin
      int   r0, f0, p0, n;
      int   rep_pos[$];
      logic [1:0] st;

      vecs[0] = '{1'b0, 20, 1'b0, 0, 0, 0};  // idle
      vecs[1] = '{1'b1,  8, 1'b0, 0, 0, 0};  // 2-tick bounce high
      vecs[2] = '{1'b0, 20, 1'b0, 0, 0, 0};
      vecs[3] = '{1'b1, 20, 1'b1, 1, 0, 0};  // clean press
      vecs[4] = '{1'b0,  8, 1'b1, 0, 0, 0};  // 2-tick bounce low
      vecs[5] = '{1'b1, 16, 1'b1, 0, 0, 0};
      vecs[6] = '{1'b0, 20, 1'b0, 0, 1, 0};  // clean release
      vecs[7] = '{1'b1,  4, 1'b0, 0, 0, 0};  // 1-tick glitch
      vecs[8] = '{1'b0, 20, 1'b0, 0, 0, 0};

      rst    = 1'b1;
      btn_in = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check("reset_level", level, 0);
      check("reset_rise", rise, 0);
      check("reset_fall", fall, 0);
      check("reset_rep", rep, 0);
      rst = 1'b0;

      // Table-driven level/pulse vectors.
      for (int i = 0; i < 9; i++) begin
         r0 = rise_n; f0 = fall_n; p0 = rep_n;
         btn_in = vecs[i].btn;
         repeat (vecs[i].cycles) @(negedge clk);
         #1;
         check($sformatf("vec%0d_level", i), level, vecs[i].exp_level);
         check($sformatf("vec%0d_rise", i), rise_n - r0, vecs[i].exp_rise);
         check($sformatf("vec%0d_fall", i), fall_n - f0, vecs[i].exp_fall);
         check($sformatf("vec%0d_rep", i), rep_n - p0, vecs[i].exp_rep);
      end

      // Clean press: latency, single rise, then repeat positions while held.
      r0 = rise_n; f0 = fall_n;
      btn_in = 1'b1;
      wait_level(1'b1, n);
      check_range("press_latency", n, 11, 14);
      rep_pos.delete();
      for (int k = 1; k <= 62; k++) begin
         @(posedge clk);
         #1;
         if (rep) rep_pos.push_back(k);
      end
      check("press_rise_count", rise_n - r0, 1);
      check("press_no_fall", fall_n - f0, 0);
`ifdef DEBOUNCE_REPEAT_EN
      check("rep_pulse_count", rep_pos.size(), 6);
      for (int i = 0; i < 6; i++) begin
         check($sformatf("rep_pos%0d", i),
               (i < rep_pos.size()) ? rep_pos[i] : -1, 4 * (5 + 2 * i));
      end
`else
      check("rep_tied_low", rep_pos.size(), 0);
`endif

      // Clean release after hold.
      r0 = rise_n; f0 = fall_n;
      btn_in = 1'b0;
      wait_level(1'b0, n);
      check_range("release_latency", n, 11, 14);
      repeat (4) @(negedge clk);
      #1;
      check("release_fall_count", fall_n - f0, 1);
      check("release_no_rise", rise_n - r0, 0);

      // Reset in WAIT_HIGH with count=2: 8 edges of btn_s=1 hold exactly two ticks.
      repeat (8) @(negedge clk);
      #1;
      btn_in = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      st = dut.state;
      check("pre_rst_state_wait_high", st, 1);
      check("pre_rst_count", dut.stable_cnt, 2);
      rst = 1'b1;
      #1;
      st = dut.state;
      check("rst_state_low", st, 0);
      check("rst_count", dut.stable_cnt, 0);
      check("rst_presc", dut.presc, 0);
      check("rst_sync", {dut.sync1, dut.btn_s}, 0);
      check("rst_outputs", {level, rise, fall, rep}, 0);
      btn_in = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      r0 = rise_n; f0 = fall_n; p0 = rep_n;
      rst = 1'b0;
      repeat (40) @(negedge clk);
      #1;
      check("post_rst_pulses", (rise_n - r0) + (fall_n - f0) + (rep_n - p0), 0);
      check("post_rst_level", level, 0);

      // Reset released with button held: debounced as a fresh press.
      rst    = 1'b1;
      btn_in = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      r0 = rise_n;
      rst = 1'b0;
      wait_level(1'b1, n);
      check_range("held_through_rst_latency", n, 11, 14);
      repeat (2) @(negedge clk);
      #1;
      check("held_through_rst_rise", rise_n - r0, 1);
      btn_in = 1'b0;
      repeat (24) @(negedge clk);
      #1;
      check("held_through_rst_released", level, 0);

      // Toggle stage fed by level: one change per release.
      tgl_clr = 1'b1;
      @(negedge clk);
      #1;
      tgl_clr = 1'b0;
      for (int p = 0; p < 2; p++) begin
         btn_in = 1'b1;
         repeat (24) @(negedge clk);
         #1;
         check($sformatf("toggle_press%0d", p), tgl, p);
         btn_in = 1'b0;
         repeat (24) @(negedge clk);
         #1;
         check($sformatf("toggle_release%0d", p), tgl, (p == 0) ? 1 : 0);
      end

      check("rise_fall_never_together", overlap_n, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/button_debounce.md
BUTTON_DEBOUNCE -- requirements
Module: button_debounce

Interface
REQ-001 The block SHALL have parameter SAMPLE_DIV, default 1000, clk cycles per sample tick (legal range 2..65535).
REQ-002 The block SHALL have parameter STABLE_TICKS, default 8, consecutive equal sample ticks needed to accept a new level (legal range 1..255).
REQ-003 The block SHALL have parameter REPEAT_DELAY, default 500, sample ticks held before the first repeat pulse (used only with DEBOUNCE_REPEAT_EN).
REQ-004 The block SHALL have parameter REPEAT_RATE, default 100, sample ticks between later repeat pulses (used only with DEBOUNCE_REPEAT_EN).
REQ-005 The block SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-006 The block SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-007 The block SHALL have port btn_in  input  1  raw push-button level, asynchronous to clk, may bounce.
REQ-008 The block SHALL have port level  output  1  debounced button level; feeds the toggle stage input.
REQ-009 The block SHALL have port rise  output  1  one-clk pulse when level goes 0->1.
REQ-010 The block SHALL have port fall  output  1  one-clk pulse when level goes 1->0.
REQ-011 The block SHALL have port rep  output  1  one-clk auto-repeat pulse while level=1.

Function
REQ-012 btn_in SHALL pass through a 2-flop synchronizer to give btn_s; no other logic SHALL use btn_in.
REQ-013 The prescaler SHALL count 0..SAMPLE_DIV-1, wrap to 0, and assert internal tick for one clk when it equals SAMPLE_DIV-1.
REQ-014 The FSM SHALL have four states: LOW, WAIT_HIGH, HIGH, WAIT_LOW; it SHALL act only on ticks.
REQ-015 LOW, tick with btn_s=1: go to WAIT_HIGH with stable count=1; with btn_s=0: stay.
REQ-016 WAIT_HIGH, tick with btn_s=1: increment count; with btn_s=0: return to LOW and clear count.
REQ-017 When count reaches STABLE_TICKS in WAIT_HIGH (including STABLE_TICKS=1 on the entry tick), the FSM SHALL enter HIGH, set level=1 and pulse rise on the same edge.
REQ-018 HIGH/WAIT_LOW SHALL mirror REQ-015..017 with polarity inverted, ending in LOW with level=0 and a fall pulse.
REQ-019 level, rise, fall, rep SHALL be registered outputs; rise and fall SHALL never be high together.
REQ-020 Latency from a clean btn_in step to level change SHALL lie within 2 + (STABLE_TICKS-1)*SAMPLE_DIV + 1 and 2 + STABLE_TICKS*SAMPLE_DIV clk cycles.
REQ-021 Any bounce during WAIT_* lasting fewer than STABLE_TICKS ticks SHALL leave level unchanged and emit no pulse.
REQ-022 The stable counter SHALL saturate and never wrap; the prescaler SHALL run freely regardless of state.

Reset
REQ-023 While rst=1: level=0, rise=0, fall=0, rep=0, FSM=LOW, all counters and synchronizer flops 0.
REQ-024 rst asserted mid-debounce or mid-repeat SHALL abort immediately; no pulse SHALL appear on rst release.
REQ-025 After rst release with btn_in held 1, the block SHALL debounce it as a new press (rise pulse after REQ-020 latency).

Configuration
REQ-026 With macro DEBOUNCE_REPEAT_EN defined: in HIGH, a repeat counter SHALL pulse rep after REPEAT_DELAY ticks and then every REPEAT_RATE ticks; it SHALL clear on leaving HIGH.
REQ-027 Without DEBOUNCE_REPEAT_EN: rep SHALL be tied 0 and no repeat counter SHALL be synthesized.

Verification (SAMPLE_DIV=4, STABLE_TICKS=3, REPEAT_DELAY=5, REPEAT_RATE=2)
REQ-028 Clean step btn_in 0->1 held -> level=1 and a single rise pulse within 11..14 clk; no fall.
REQ-029 btn_in high for 2 ticks then low (bounce) -> level stays 0; rise, fall, rep stay 0.
REQ-030 Press, hold, then clean release -> exactly one rise, then one fall 11..14 clk after release.
REQ-031 rst pulsed while in WAIT_HIGH with count=2 -> all outputs 0 and FSM=LOW at the next edge; no pulse after release if btn_in=0.
REQ-032 DEBOUNCE_REPEAT_EN defined, hold 15 ticks after level=1 -> rep at ticks 5, 7, 9, 11, 13, 15 after entering HIGH; undefined -> rep always 0.
REQ-033 Chain level into the toggle stage, press/release twice -> toggle output 0->1->0, one change per release.
